// File: rtl/reg_arb_pkg.sv
// Shared definitions for the round-robin register write arbiter.
//   state_t : arbiter phase encoding (IDLE=0, GRANT=1, RELEASE=2; code 3 recovers to IDLE)
//   clog2   : index width helper, never returns less than 1
package reg_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    if (r < 1) r = 1;
    return r;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Bus between NUM_REQ producers and the shared-register arbiter.
//   REQ   : per-requester write request (level)
//   D     : packed data lanes, lane i = D[i*DATA_WIDTH +: DATA_WIDTH]
//   GNT   : one-hot grant, high for exactly one cycle
//   ACK   : write-done pulse, one cycle after GNT
//   OWNER : index of the requester that last wrote Q
//   Q     : shared register value
//
// Handshake: a requester holds REQ (and its lane) until it sees GNT. If REQ
// is still high on the edge that ends the GNT cycle, its lane is written and
// ACK pulses in the following cycle; if REQ was dropped the grant is
// abandoned with no write and no ACK. REQ still high at the edge that ends
// the ACK cycle is treated as a fresh request.
interface reg_write_arbiter_if import reg_arb_pkg::*; #(
  parameter int DATA_WIDTH = 4,
  parameter int NUM_REQ    = 4
);
  localparam int IDX_W = clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            REQ;
  logic [NUM_REQ*DATA_WIDTH-1:0] D;
  logic [NUM_REQ-1:0]            GNT;
  logic                          ACK;
  logic [IDX_W-1:0]              OWNER;
  logic [DATA_WIDTH-1:0]         Q;

  modport master (output REQ, D, input GNT, ACK, OWNER, Q);
  modport slave  (input REQ, D, output GNT, ACK, OWNER, Q);

endinterface

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req    : request vector
//   ptr    : index where the search starts (always < NUM_REQ)
//   winner : first set request at or above ptr, wrapping NUM_REQ-1 -> 0
//   onehot : winner as a one-hot vector, zero when no request
//   any_req: at least one request is set
module rr_pick import reg_arb_pkg::*; #(
  parameter int NUM_REQ = 4,
  localparam int IDX_W  = clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   winner,
  output logic [NUM_REQ-1:0] onehot,
  output logic               any_req
);

  int   idx;
  logic found;

  always_comb begin
    winner = '0;
    onehot = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr) + k;
      // explicit wrap so non-power-of-two NUM_REQ stays in range
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req[IDX_W'(idx)]) begin
        found  = 1'b1;
        winner = IDX_W'(idx);
      end
    end
    if (found) onehot[winner] = 1'b1;
  end

  assign any_req = |req;

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing one DATA_WIDTH-bit register among NUM_REQ
// requesters. One write takes three cycles: GNT cycle, ACK cycle, then the
// next arbitration.
//   C         : clock, rising edge
//   CLR       : asynchronous active-high reset (Q <= CLEAR_VAL)
//   bus       : slave side of reg_write_arbiter_if (REQ, D in; GNT, ACK, OWNER, Q out)
//   state_dbg : current arbiter phase (state_t encoding)
module reg_write_arbiter import reg_arb_pkg::*; #(
  parameter int                    DATA_WIDTH = 4,
  parameter int                    NUM_REQ    = 4,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VAL  = '0
) (
  input  logic                 C,
  input  logic                 CLR,
  reg_write_arbiter_if.slave   bus,
  output logic [1:0]           state_dbg
);

  localparam int IDX_W = clog2(NUM_REQ);

  state_t                state, state_nxt;
  logic [NUM_REQ-1:0]    gnt, gnt_nxt;
  logic                  ack, ack_nxt;
  logic [IDX_W-1:0]      owner, owner_nxt;
  logic [IDX_W-1:0]      ptr, ptr_nxt;
  logic [IDX_W-1:0]      w, w_nxt;
  logic [DATA_WIDTH-1:0] q, q_nxt;

  logic [DATA_WIDTH-1:0] lane [NUM_REQ];
  logic [IDX_W-1:0]      pick_idx;
  logic [NUM_REQ-1:0]    pick_onehot;
  logic                  pick_any;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign lane[i] = bus.D[i*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req     (bus.REQ),
    .ptr     (ptr),
    .winner  (pick_idx),
    .onehot  (pick_onehot),
    .any_req (pick_any)
  );

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      state <= ST_IDLE;
      gnt   <= '0;
      ack   <= 1'b0;
      owner <= '0;
      ptr   <= '0;
      w     <= '0;
      q     <= CLEAR_VAL;
    end else begin
      state <= state_nxt;
      gnt   <= gnt_nxt;
      ack   <= ack_nxt;
      owner <= owner_nxt;
      ptr   <= ptr_nxt;
      w     <= w_nxt;
      q     <= q_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    ack_nxt   = ack;
    owner_nxt = owner;
    ptr_nxt   = ptr;
    w_nxt     = w;
    q_nxt     = q;
    case (state)
      ST_IDLE: begin
        if (pick_any) begin
          gnt_nxt   = pick_onehot;
          w_nxt     = pick_idx;
          state_nxt = ST_GRANT;
        end
      end
      ST_GRANT: begin
        gnt_nxt = '0;
        // pointer moves past the winner whether or not it wrote
        ptr_nxt = (w == IDX_W'(NUM_REQ - 1)) ? '0 : w + IDX_W'(1);
        if (bus.REQ[w]) begin
          q_nxt     = lane[w];
          owner_nxt = w;
          ack_nxt   = 1'b1;
          state_nxt = ST_RELEASE;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_RELEASE: begin
        ack_nxt   = 1'b0;
        state_nxt = ST_IDLE;
      end
      default: begin
        gnt_nxt   = '0;
        ack_nxt   = 1'b0;
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign bus.GNT   = gnt;
  assign bus.ACK   = ack;
  assign bus.OWNER = owner;
  assign bus.Q     = q;
  assign state_dbg = state;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Bench for reg_write_arbiter: directed scenarios with literal expectations
// plus a randomized phase, all cross-checked every cycle against a
// transaction-level model of the arbiter.
module tb_reg_write_arbiter;

  localparam int         DW      = 4;
  localparam int         NR      = 4;
  localparam logic [3:0] CLR_VAL = 4'hA;

  // ---------------- clock / reset ----------------
  logic       C   = 1'b0;
  logic       CLR = 1'b1;
  logic [1:0] state_dbg;

  always #5 C = ~C;

  reg_write_arbiter_if #(.DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();

  reg_write_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR),
    .CLEAR_VAL  (CLR_VAL)
  ) dut (
    .C         (C),
    .CLR       (CLR),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard counters ----------------
  int n_pass  = 0;
  int n_total = 0;
  bit run_cmp = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  // Tracks the outstanding grant (if any), the ACK cycle, the register,
  // the last writer and the round-robin start point.
  bit         m_gnt_on = 1'b0;
  bit         m_ack    = 1'b0;
  int         m_w      = 0;
  int         m_owner  = 0;
  int         m_ptr    = 0;
  logic [3:0] m_q      = CLR_VAL;

  always @(posedge C or posedge CLR) begin
    if (CLR) begin
      m_gnt_on = 1'b0;
      m_ack    = 1'b0;
      m_w      = 0;
      m_owner  = 0;
      m_ptr    = 0;
      m_q      = CLR_VAL;
    end else if (m_ack) begin
      m_ack = 1'b0;
    end else if (m_gnt_on) begin
      m_gnt_on = 1'b0;
      m_ptr    = (m_w + 1) % NR;
      if (bus.REQ[m_w]) begin
        m_q     = bus.D[m_w*DW +: DW];
        m_owner = m_w;
        m_ack   = 1'b1;
      end
    end else if (bus.REQ != '0) begin
      for (int k = NR - 1; k >= 0; k--)
        if (bus.REQ[(m_ptr + k) % NR]) m_w = (m_ptr + k) % NR;
      m_gnt_on = 1'b1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge C) begin
    logic [3:0] exp_g;
    if (run_cmp && !CLR) begin
      exp_g = m_gnt_on ? 4'(1 << m_w) : 4'b0;
      check("cyc_gnt",   32'(bus.GNT),   32'(exp_g));
      check("cyc_ack",   32'(bus.ACK),   32'(m_ack));
      check("cyc_owner", 32'(bus.OWNER), 32'(m_owner));
      check("cyc_q",     32'(bus.Q),     32'(m_q));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge C);
    #2;
  endtask

  task automatic wait_gnt();
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (bus.GNT == '0 && n < 8);
  endtask

  // full write by one winner: GNT cycle, ACK cycle, then REQ dropped
  task automatic do_write(input logic [3:0] pattern, input int exp_w,
                          input logic [3:0] exp_d, input string tag);
    bus.REQ = pattern;
    wait_gnt();
    check({tag, "_gnt"},     32'(bus.GNT), 32'(1 << exp_w));
    check({tag, "_gnt_ack"}, 32'(bus.ACK), 32'd0);
    tick();
    check({tag, "_ack"},   32'(bus.ACK),   32'd1);
    check({tag, "_owner"}, 32'(bus.OWNER), 32'(exp_w));
    check({tag, "_q"},     32'(bus.Q),     32'(exp_d));
    check({tag, "_ack_gnt"}, 32'(bus.GNT), 32'd0);
    bus.REQ = '0;
    tick();
    check({tag, "_rel_ack"}, 32'(bus.ACK), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_q"},     32'(bus.Q),     32'(CLR_VAL));
    check({tag, "_gnt"},   32'(bus.GNT),   32'd0);
    check({tag, "_ack"},   32'(bus.ACK),   32'd0);
    check({tag, "_owner"}, 32'(bus.OWNER), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] rr_q[$];
    int         ro_q[$];
    int         last, acks;

    bus.REQ = '0;
    bus.D   = '0;
    repeat (2) @(posedge C);
    #2;
    check_reset_vals("reset");
    CLR     = 1'b0;
    run_cmp = 1'b1;

    // single request from requester 2, no regrant after REQ drops
    bus.D = 16'h0500;
    do_write(4'b0100, 2, 4'h5, "single");
    tick();
    check("single_no_regrant", 32'(bus.GNT), 32'd0);
    check("single_no_ack",     32'(bus.ACK), 32'd0);

    // asynchronous clear mid-cycle, then all four requesting continuously
    CLR = 1'b1;
    #1;
    check_reset_vals("async_clr");
    bus.D   = 16'h4321;
    bus.REQ = 4'b1111;
    #1 CLR = 1'b0;
    rr_q = {4'h1, 4'h2, 4'h3, 4'h4, 4'h1};
    ro_q = {0, 1, 2, 3, 0};
    last = -1;
    acks = 0;
    for (int c = 0; c < 30 && acks < 5; c++) begin
      tick();
      if (bus.ACK) begin
        check("rr_q",     32'(bus.Q),     32'(rr_q.pop_front()));
        check("rr_owner", 32'(bus.OWNER), 32'(ro_q.pop_front()));
        if (last >= 0) check("rr_spacing", 32'(c - last), 32'd3);
        last = c;
        acks++;
        if (acks == 5) bus.REQ = '0;
      end
    end
    check("rr_count", 32'(acks), 32'd5);
    tick();
    check("rr_idle_gnt", 32'(bus.GNT), 32'd0);

    // skip and wrap of the pointer
    do_write(4'b1000, 3, 4'h4, "skip3");
    do_write(4'b0011, 0, 4'h1, "wrap0");
    do_write(4'b0011, 1, 4'h2, "next1");
    do_write(4'b1000, 3, 4'h4, "only3a");
    do_write(4'b1000, 3, 4'h4, "only3b");

    // requester 1 withdraws during its grant cycle
    bus.D   = 16'h00F0;
    bus.REQ = 4'b0010;
    wait_gnt();
    check("wd_gnt", 32'(bus.GNT), 32'b0010);
    bus.REQ = '0;
    tick();
    check("wd_ack",   32'(bus.ACK),   32'd0);
    check("wd_q",     32'(bus.Q),     32'h4);
    check("wd_owner", 32'(bus.OWNER), 32'd3);
    check("wd_gnt0",  32'(bus.GNT),   32'd0);
    bus.D = 16'h4321;
    do_write(4'b1111, 2, 4'h3, "wd_next");

    // clear while a grant is outstanding; pointer must restart at 0
    bus.REQ = 4'b0100;
    wait_gnt();
    check("cg_gnt", 32'(bus.GNT), 32'b0100);
    CLR = 1'b1;
    #1;
    check_reset_vals("cg_clr");
    bus.REQ = '0;
    #1 CLR = 1'b0;
    do_write(4'b1001, 0, 4'h1, "post_clr");

    // randomized traffic with occasional asynchronous clears
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 2) == 0) bus.REQ = 4'($urandom_range(0, 15));
      bus.D = 16'($urandom);
      if ($urandom_range(0, 79) == 0) begin
        CLR = 1'b1;
        #1;
        check("rnd_clr_q",   32'(bus.Q),   32'(CLR_VAL));
        check("rnd_clr_ack", 32'(bus.ACK), 32'd0);
        #1 CLR = 1'b0;
      end
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
